if_prefetch: RTL
================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter XLEN, default 32: address and instruction width.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, >=2): prefetch buffer entries.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 jmp_en  in  1  redirect request (jump, jump-register, taken branch merged upstream).
REQ-007 jmp_to  in  XLEN  redirect target; ignored unless jmp_en.
REQ-008 req_valid/req_ready/req_addr  out/in/out  1/1/XLEN  instruction-memory request handshake.
REQ-009 rsp_valid/rsp_data  in/in  1/XLEN  memory response; in order, at least 1 cycle after request acceptance, no backpressure.
REQ-010 instr_valid/instr_ready  out/in  1/1  decode-side handshake.
REQ-011 instr_data/instr_pc  out  XLEN/XLEN  head-of-buffer instruction and its address.
REQ-012 stall_cnt  out  32  present only under IF_STALL_CNT_EN.

Function
REQ-013 Fetch PC register fpc; a request is accepted when req_valid && req_ready; fpc then advances by 4 (mod 2^XLEN, wraps silently).
REQ-014 req_addr SHALL equal fpc combinationally; req_valid SHALL be high iff (fifo_count + outstanding) < FIFO_DEPTH and no redirect in the current cycle.
REQ-015 outstanding counter: +1 on accepted request, -1 on consumed response, both in one cycle = unchanged; width clog2(FIFO_DEPTH)+1.
REQ-016 Each accepted request pushes its address into a PC-tag queue; each non-dropped response writes {rsp_data, tag} into the FIFO the same edge.
REQ-017 instr_valid SHALL be high iff FIFO non-empty; latency from rsp_valid to instr_valid is one cycle.
REQ-018 Pop on instr_valid && instr_ready; simultaneous push and pop when full is impossible by REQ-014 credit rule; push and pop in the same cycle keep count unchanged.
REQ-019 Redirect (jmp_en): fpc <= jmp_to, FIFO and tag queue flushed, instr_valid low next cycle, drop counter <= outstanding (minus response consumed this cycle).
REQ-020 While drop counter > 0, responses are discarded and decrement it; no FIFO write.
REQ-021 jmp_en coincident with instr_ready: pop is ignored, flush wins; jmp_en coincident with request acceptance: request is not issued (REQ-014).
REQ-022 Back-to-back redirects: latest jmp_to wins, drop counter accumulates correctly.
REQ-023 jmp_to not 4-byte aligned: used as-is, no alignment check.

Reset
REQ-024 On rst: fpc <= RESET_PC, FIFO/tag queue empty, outstanding 0, drop 0, req_valid 0 during reset cycle, instr_valid 0, instr_data/instr_pc 0, stall_cnt 0.
REQ-025 rst mid-operation: in-flight responses after reset are not dropped; memory SHALL be reset concurrently by the system.

Configuration
REQ-026 Macro IF_STALL_CNT_EN: defined -> stall_cnt port exists and increments (saturating at 2^32-1) each cycle instr_ready && !instr_valid && !rst; undefined -> port and counter absent, no other behavioural change.

Structure
REQ-027 Shared package if_pkg holds XLEN default, RESET_PC default, instruction NOP constant 32'h0000_0013, fifo entry typedef {data, pc}.
REQ-028 One sub-module if_fifo (parametrised depth/width, sync, with flush) used for both data FIFO and tag queue; fetch control remains in if_prefetch.

Verification
REQ-029 Reset, req_ready=1, memory 1-cycle latency, instr_ready=1 -> req_addr 0x0,0x4,0x8...; instr_pc matches, steady 1 instr/cycle.
REQ-030 instr_ready=0 for 10 cycles -> exactly 4 requests issued, req_valid low, FIFO holds 0x0-0xC; release -> drained in order.
REQ-031 Memory latency 3 cycles, 3 outstanding, jmp_en with jmp_to=0x100 -> 3 stale responses dropped, first instr_pc 0x100.
REQ-032 jmp_en in two consecutive cycles (0x200 then 0x300) -> no 0x200 instruction delivered; first instr_pc 0x300.
REQ-033 fpc=0xFFFF_FFFC via redirect -> next req_addr 0x0000_0000.
REQ-034 IF_STALL_CNT_EN defined, req_ready=0 for 5 cycles with instr_ready=1 after reset -> stall_cnt=5 (plus initial empty cycles, checked exactly).

Source files
------------

// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg -- shared definitions for the instruction-fetch slice.
//
// Contents:
//   IF_XLEN      default address / instruction width
//   IF_RESET_PC  default first fetch address after reset
//   IF_NOP       canonical NOP encoding (addi x0, x0, 0)
//   fifo_entry_t one prefetch buffer entry {data, pc}
// ---------------------------------------------------------------------------
package if_pkg;

    localparam int          IF_XLEN     = 32;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IF_NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [IF_XLEN-1:0] data;
        logic [IF_XLEN-1:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// ---------------------------------------------------------------------------
// if_prefetch_if -- bundle of the fetch unit's memory and decode handshakes.
//
// Signals:
//   req_valid/req_ready/req_addr   instruction-memory request
//   rsp_valid/rsp_data             in-order memory response, no backpressure
//   instr_valid/instr_ready        decode-side handshake
//   instr_data/instr_pc            head-of-buffer instruction and address
// Modports:
//   master  fetch unit side
//   slave   memory + decode side (environment)
// ---------------------------------------------------------------------------
interface if_prefetch_if
    import if_pkg::*;
#(
    parameter int XLEN = IF_XLEN
);

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output req_valid, req_addr,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready,
        output rsp_valid, rsp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/if_fifo.sv
// ---------------------------------------------------------------------------
// if_fifo -- synchronous FIFO with flush, used for the instruction buffer and
// for the PC-tag queue of outstanding requests.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset (storage cleared to zero)
//   flush  empties the FIFO (pointers/count only)
//   push   write wdata (ignored when full)
//   wdata  write data
//   pop    drop head entry (ignored when empty)
//   rdata  head entry
//   count  number of stored entries
// DEPTH must be a power of two >= 2.
// ---------------------------------------------------------------------------
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    // Qualify requests against occupancy.
    always_comb begin
        push_s = push && (count_r != (AW+1)'(DEPTH));
        pop_s  = pop && (count_r != {(AW+1){1'b0}});
    end

    // Pointers, occupancy and storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch -- instruction prefetch unit with redirect and stale-response
// dropping.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   jmp_en, jmp_to  redirect request and target (target used as-is)
//   bus             if_prefetch_if.master: memory request/response and
//                   decode handshakes
//   stall_cnt       decode-stall cycle counter (only with IF_STALL_CNT_EN)
//
// Optional feature macro: IF_STALL_CNT_EN adds the saturating stall_cnt
// output, counting cycles where decode is ready but the buffer is empty.
//
// Requests are credit limited: buffered entries plus responses in flight
// never exceed FIFO_DEPTH, so a response always finds room in the buffer.
// ---------------------------------------------------------------------------
module if_prefetch
    import if_pkg::*;
#(
    parameter int              XLEN       = IF_XLEN,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = IF_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_to,
    if_prefetch_if.master   bus
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]   fpc_r;
    logic [CW-1:0]     outstanding_r;
    logic [CW-1:0]     drop_r;
    logic [CW-1:0]     data_count_s;
    logic [CW-1:0]     tag_count_s;
    logic [XLEN-1:0]   tag_pc_s;
    logic [2*XLEN-1:0] head_s;
    logic              credit_ok_s;
    logic              req_fire_s;
    logic              rsp_keep_s;
    logic              pop_s;

    assign credit_ok_s = ({1'b0, data_count_s} + {1'b0, outstanding_r}) < (CW+1)'(FIFO_DEPTH);

    // Outward handshakes; a redirect cycle never issues a request.
    always_comb begin
        if (!rst && !jmp_en && credit_ok_s) begin
            bus.req_valid = 1'b1;
        end else begin
            bus.req_valid = 1'b0;
        end
        bus.req_addr    = fpc_r;
        bus.instr_valid = (data_count_s != {CW{1'b0}});
        bus.instr_data  = head_s[2*XLEN-1:XLEN];
        bus.instr_pc    = head_s[XLEN-1:0];
    end

    // Transfer qualifiers; a redirect overrides pop and buffer writes.
    always_comb begin
        req_fire_s = bus.req_valid && bus.req_ready;
        rsp_keep_s = bus.rsp_valid && (drop_r == {CW{1'b0}}) && !jmp_en
                     && (tag_count_s != {CW{1'b0}});
        pop_s      = bus.instr_valid && bus.instr_ready && !jmp_en;
    end

    // Fetch PC: reset, redirect, or advance on accepted request (wraps).
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_r <= RESET_PC;
        end else if (jmp_en) begin
            fpc_r <= jmp_to;
        end else if (req_fire_s) begin
            fpc_r <= fpc_r + XLEN'(3'd4);
        end else begin
            fpc_r <= fpc_r;
        end
    end

    // Responses still owed by memory, including ones that will be dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= {CW{1'b0}};
        end else begin
            case ({req_fire_s, bus.rsp_valid})
                2'b10:   outstanding_r <= outstanding_r + CW'(1'b1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1'b1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Stale-response counter; a redirect re-arms it with everything in flight
    // except a response that is being consumed this same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_r <= {CW{1'b0}};
        end else if (jmp_en) begin
            drop_r <= outstanding_r - (bus.rsp_valid ? CW'(1'b1) : {CW{1'b0}});
        end else if (bus.rsp_valid && (drop_r != {CW{1'b0}})) begin
            drop_r <= drop_r - CW'(1'b1);
        end else begin
            drop_r <= drop_r;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jmp_en),
        .push  (req_fire_s),
        .wdata (fpc_r),
        .pop   (rsp_keep_s),
        .rdata (tag_pc_s),
        .count (tag_count_s)
    );

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jmp_en),
        .push  (rsp_keep_s),
        .wdata ({bus.rsp_data, tag_pc_s}),
        .pop   (pop_s),
        .rdata (head_s),
        .count (data_count_s)
    );

`ifdef IF_STALL_CNT_EN
    // Saturating count of cycles where decode waits on an empty buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (bus.instr_ready && !bus.instr_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`endif

endmodule
